muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 61 ++++++
 rtl/muldiv_div_step.sv | 23 ++
 rtl/muldiv_seq.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared RV32 ALU op codes and small decode helpers for the multiply/divide unit.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package muldiv_seq_pkg;

  // Base integer ALU ops (not handled by the multiply/divide unit)
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_AND    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;

  // RV32M ops
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  function automatic logic op_is_mul(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Divide ops that treat both operands as two's complement
  function automatic logic op_div_signed(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  // Divide ops that return the remainder rather than the quotient
  function automatic logic op_is_rem(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Multiply ops where operand a is sign-extended
  function automatic logic op_mul_a_signed(input logic [4:0] op);
    return (op == ALU_MULH) || (op == ALU_MULHSU);
  endfunction

  // Multiply ops where operand b is sign-extended
  function automatic logic op_mul_b_signed(input logic [4:0] op);
    return (op == ALU_MULH);
  endfunction

  // Multiply ops returning the upper half of the product
  function automatic logic op_mul_high(input logic [4:0] op);
    return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register.
module muldiv_div_step
  import muldiv_seq_pkg::*;
(
  input  logic [31:0] rem_in,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  // The shifted partial remainder needs 33 bits; after a successful
  // subtract (or when no subtract happens) the value is always below the
  // divisor, so the upper bit can be dropped safely.
  logic [32:0] shifted;

  assign shifted = {rem_in, dvd_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = 32'(q_bit ? (shifted - {1'b0, divisor}) : shifted);

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: MUL_CYCLES-cycle multiply, 32-step restoring divide.
// Latency: MUL_CYCLES+1 multiply, 34 divide, 2 for special/illegal cases (accept edge to done).
// Backpressure: one op at a time; start is ignored while busy, flush aborts without done.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 2
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DIV   = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int                 CNT_W    = 6;
  localparam logic [CNT_W-1:0]   MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(31);

  state_t             state;
  logic [4:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        rem_q;     // partial remainder
  logic [31:0]        quo_q;     // dividend magnitude shifting out, quotient shifting in
  logic [31:0]        dsr_q;     // divisor magnitude
  logic [31:0]        res_q;     // divide-path result chosen in FIXUP
  logic [63:0]        prod_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               err_q;

  // Accept-time operand decode
  logic               in_a_neg;
  logic               in_b_neg;
  logic [31:0]        in_a_mag;
  logic [31:0]        in_b_mag;
  logic               in_special;

  // Datapath
  logic [31:0]        step_rem;
  logic               step_q;
  logic [63:0]        mul_ea;
  logic [63:0]        mul_eb;
  logic [63:0]        mul_full;
  logic [31:0]        mul_res;
  logic [31:0]        fix_res;

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  assign in_a_neg   = op_div_signed(op) & a[31];
  assign in_b_neg   = op_div_signed(op) & b[31];
  assign in_a_mag   = in_a_neg ? (32'd0 - a) : a;
  assign in_b_mag   = in_b_neg ? (32'd0 - b) : b;
  assign in_special = (b == 32'd0) ||
                      (op_div_signed(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));

  muldiv_div_step u_div_step (
    .rem_in  (rem_q),
    .dvd_bit (quo_q[31]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Extending both operands to 64 bits and keeping the low 64 product bits
  // gives the correct signed, unsigned or mixed product without a wider multiplier.
  assign mul_ea   = {{32{op_mul_a_signed(op_q) & a_q[31]}}, a_q};
  assign mul_eb   = {{32{op_mul_b_signed(op_q) & b_q[31]}}, b_q};
  assign mul_full = mul_ea * mul_eb;
  assign mul_res  = op_mul_high(op_q) ? prod_q[63:32] : prod_q[31:0];

  // Divide-path result selection: illegal op, divide by zero, overflow, then sign fixup
  always_comb begin
    fix_res = 32'd0;
    if (err_q) begin
      fix_res = 32'd0;
    end else if (b_q == 32'd0) begin
      fix_res = op_is_rem(op_q) ? a_q : 32'hFFFF_FFFF;
    end else if (op_div_signed(op_q) && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
      fix_res = op_is_rem(op_q) ? 32'd0 : 32'h8000_0000;
    end else if (op_is_rem(op_q)) begin
      fix_res = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    end else begin
      fix_res = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    end
  end

  // Control FSM with registered done/result/err; done is raised on the edge leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dsr_q     <= 32'd0;
      res_q     <= 32'd0;
      prod_q    <= 64'd0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      err_q     <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_q      <= op;
              a_q       <= a;
              b_q       <= b;
              quo_q     <= in_a_mag;
              dsr_q     <= in_b_mag;
              rem_q     <= 32'd0;
              cnt_q     <= '0;
              neg_quo_q <= in_a_neg ^ in_b_neg;
              neg_rem_q <= in_a_neg;
              err_q     <= 1'b0;
              if (op_is_mul(op)) begin
                state <= MUL;
              end else if (op_is_div(op)) begin
                state <= in_special ? FIXUP : DIV;
              end else begin
                state <= FIXUP;
                err_q <= 1'b1;
              end
            end
          end
          MUL: begin
            prod_q <= mul_full;
            if (cnt_q == MUL_LAST) begin
              cnt_q <= '0;
              state <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DIV: begin
            rem_q <= step_rem;
            quo_q <= {quo_q[30:0], step_q};
            if (cnt_q == DIV_LAST) begin
              cnt_q <= '0;
              state <= FIXUP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          FIXUP: begin
            res_q <= fix_res;
            state <= DONE;
          end
          DONE: begin
            done   <= 1'b1;
            result <= op_is_mul(op_q) ? mul_res : res_q;
            err    <= err_q;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a queue-based scoreboard and a done monitor.
// Latency: edges counted from the accepting edge (edge 0) to the edge on which done rises.
// Backpressure: stimulus waits for ready before issuing.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  typedef struct {
    logic [31:0] res;
    logic        er;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.MUL_CYCLES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    chk(name, {31'd0, act}, {31'd0, expv});
  endtask

  // Rising-edge counter used to time done relative to the accepting edge
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with result %h want no done", result);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_res"}, result, e.res);
          chk1({e.name, "_err"}, err, e.er);
          chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  // Issue one op at a negedge once ready, and queue its expected response
  task automatic issue(input string name, input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input logic ee,
                       input int el);
    exp_t e;
    for (int n = 0; n < 100 && ready !== 1'b1; n++) @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e.res  = er;
    e.er   = ee;
    e.lat  = el;
    e.acc  = cyc;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) until every queued expectation has been matched
  task automatic wait_drain();
    for (int n = 0; n < 80 && sb_q.size() != 0; n++) @(negedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending results want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_done;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = ALU_ADD;
    a     = 32'd0;
    b     = 32'd0;

    #3;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    chk1("rst_err", err, 1'b0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Divide path and its special cases
    issue("div_m7_2",  ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 34); wait_drain();
    issue("rem_m7_2",  ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 34); wait_drain();
    issue("divu_z",    ALU_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 2);  wait_drain();
    issue("remu_z",    ALU_REMU, 32'd100,       32'd0,         32'd100,       1'b0, 2);  wait_drain();
    issue("div_ovf",   ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2);  wait_drain();
    issue("rem_ovf",   ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 2);  wait_drain();

    // Multiply path
    issue("mulh",      ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 3); wait_drain();
    issue("mulhsu",    ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3); wait_drain();

    // Back-to-back: next op issued in the cycle done is high
    issue("mul_lo",    ALU_MUL,    32'h0001_0000, 32'h0001_0000, 32'd0,         1'b0, 3);
    for (int n = 0; n < 20 && done !== 1'b1; n++) @(negedge clk);
    chk1("b2b_ready_with_done", ready, 1'b1);
    issue("mulhu_b2b", ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 3);
    wait_drain();

    // Flush: start ignored while busy, flush aborts without done, result held
    saved_done = done_cnt;
    op = ALU_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = ALU_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk1("busy_after_ignored_start", busy, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk1("busy_before_flush", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_ready", ready, 1'b1);
    repeat (45) @(negedge clk);
    chk("flush_no_done", 32'(done_cnt), 32'(saved_done));
    chk("flush_result_held", result, 32'hFFFF_FFFE);
    chk1("flush_err_held", err, 1'b0);

    // Reset mid-divide, then an illegal op right after release
    op = ALU_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ready", ready, 1'b1);
    chk1("midrst_done", done, 1'b0);
    chk("midrst_result", result, 32'd0);
    chk1("midrst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue("illegal_add", ALU_ADD, 32'd5, 32'd6, 32'd0, 1'b1, 2);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
